// File: rtl/switch_event_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_event_ctrl_pkg
//  Description : Shared definitions for the switch event controller: event
//                word field positions, read FSM encodings, mask reset value
//                and a helper that assembles the 32-bit event word.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_event_ctrl_pkg;

    // Event word field positions (CPU-visible layout)
    localparam int EV_VALID  = 31;
    localparam int EV_OVF    = 30;
    localparam int EV_CHG_HI = 15;
    localparam int EV_CHG_LO = 8;
    localparam int EV_ST_HI  = 7;
    localparam int EV_ST_LO  = 0;

    // Width of one queued event record: {changed[7:0], state[7:0]}
    localparam int EV_REC_W  = 16;

    // Every switch generates events out of reset
    localparam logic [7:0] MASK_RESET = 8'hFF;

    // Read handshake FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } rd_state_e;

    // Assemble the CPU-visible event word; unused bits 29:16 stay zero
    function automatic logic [31:0] pack_event(
        input logic                valid,
        input logic                ovf,
        input logic [EV_REC_W-1:0] rec
    );
        logic [31:0] word;
        word                       = '0;
        word[EV_VALID]             = valid;
        word[EV_OVF]               = ovf;
        word[EV_CHG_HI:EV_CHG_LO]  = rec[15:8];
        word[EV_ST_HI:EV_ST_LO]    = rec[7:0];
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_event_ctrl_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : event_fifo
//  Description : Synchronous FIFO for switch event records. Push and pop in
//                the same cycle both take effect, including when full, where
//                the incoming record takes the slot being freed. A push while
//                full without a pop is dropped and flagged for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module event_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,   // power of two, at least 2
    parameter int PTR_W = 3    // log2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o,
    output logic             drop_o
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic do_pop;
    logic do_push;

    // A pop on an empty FIFO is ignored; a pop frees a slot for a push when full
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        drop_o   = push_i & full_o & ~do_pop;
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards reads
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Status and head-of-queue outputs
    always_comb begin
        full_o  = (count_q == FULL_COUNT);
        empty_o = (count_q == '0);
        count_o = count_q;
        rdata_o = mem_q[rd_ptr_q];
    end

endmodule
`default_nettype wire

// File: rtl/switch_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : switch_event_ctrl
//  Description : Detects changes on the debounced switch bank, queues one
//                record per changing cycle, raises a level interrupt while
//                records are pending and serves them to the CPU through a
//                read/ack handshake. Holds a per-switch event enable mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_event_ctrl
    import switch_event_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,   // record layout assumes 8 switches
    parameter int DEPTH = 8,   // power of two, at least 2
    parameter int PTR_W = 3    // log2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_in,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             irq_en,
    input  logic             read,
    output logic             ack,
    output logic [31:0]      data_out,
    output logic             irq,
    output logic [PTR_W:0]   pending
);

    rd_state_e state_q, state_d;

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             ovf_q,  ovf_d;
    logic             irq_q,  irq_d;

    logic [WIDTH-1:0]    changed;
    logic                ev_push;
    logic [EV_REC_W-1:0] ev_rec;
    logic                ev_pop;
    logic [EV_REC_W-1:0] head_rec;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_drop;
    logic [PTR_W:0]      fifo_count;
    logic                in_ack;

    // Change detection; masked-off changes are absorbed by prev, not deferred
    always_comb begin
        changed = (switch_in ^ prev_q) & mask_q;
        ev_push = |changed;
        ev_rec  = {changed, switch_in};
        prev_d  = switch_in;
        mask_d  = mask_we ? mask_in : mask_q;
    end

    // Previous switch levels and enable mask; new mask applies next cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
            mask_q <= MASK_RESET;
        end else begin
            prev_q <= prev_d;
            mask_q <= mask_d;
        end
    end

    event_fifo #(
        .DW    (EV_REC_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (ev_push),
        .pop_i   (ev_pop),
        .wdata_i (ev_rec),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    // Read FSM state register; reset aborts any handshake in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM next state; HOLD waits for read to drop so each request pops once
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (read) state_d = ST_ACK;
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: if (!read) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read FSM outputs; an empty read reports live switch levels with valid=0
    always_comb begin
        in_ack   = (state_q == ST_ACK);
        ack      = in_ack;
        ev_pop   = in_ack;
        data_out = '0;
        if (in_ack) begin
            if (fifo_empty) begin
                data_out = pack_event(1'b0, ovf_q, {8'h00, switch_in});
            end else begin
                data_out = pack_event(1'b1, ovf_q, head_rec);
            end
        end
    end

    // Sticky overflow clears once reported, unless a drop lands in that cycle;
    // interrupt follows occupancy one cycle later
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (in_ack) begin
            ovf_d = 1'b0;
        end
        irq_d = irq_en & ~fifo_empty;
    end

    // Overflow flag and registered interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= irq_d;
        end
    end

    // Status outputs
    always_comb begin
        irq     = irq_q;
        pending = fifo_count;
    end

endmodule
`default_nettype wire
